// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: fixed-priority CPU port plus a debug port with a
// starvation guard and a lockable burst mode. Reads return one cycle later.
module dmem_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 7,
  parameter int DBG_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [XLEN-1:0]   cpu_wdata,
  input  logic [3:0]        cpu_be,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [XLEN-1:0]   cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [XLEN-1:0]   dbg_wdata,
  input  logic [3:0]        dbg_be,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [XLEN-1:0]   dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [XLEN-1:0]   wdata;
    logic [3:0]        be;
  } req_t;

  typedef enum logic {CPU_PRI = 1'b0, DBG_LOCKED = 1'b1} state_e;

  localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);

  state_e          state_q, state_d;
  logic [3:0]      wait_cnt_q, wait_cnt_d;
  logic            rd_vld_q, rd_vld_d;
  logic            rd_dbg_q, rd_dbg_d;
  logic [XLEN-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [XLEN-1:0] dbg_rdata_q, dbg_rdata_d;
  req_t            hold_q, hold_d;
  req_t            cpu_r, dbg_r, sel;
  logic            force_dbg;

  assign cpu_r     = {cpu_we, cpu_addr, cpu_wdata, cpu_be};
  assign dbg_r     = {dbg_we, dbg_addr, dbg_wdata, dbg_be};
  assign force_dbg = (wait_cnt_q == MAX_WAIT) && dbg_req;

  // Grants are suppressed while in reset even if requests are asserted.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        CPU_PRI: begin
          if (cpu_req && !force_dbg) cpu_gnt = 1'b1;
          else if (dbg_req)          dbg_gnt = 1'b1;
        end
        DBG_LOCKED: dbg_gnt = dbg_req;
        default: ;
      endcase
    end
    cpu_stall = cpu_req & ~cpu_gnt & ~rst;
  end

  // With no grant the address/data side keeps its last value.
  always_comb begin
    sel = hold_q;
    if (cpu_gnt)      sel = cpu_r;
    else if (dbg_gnt) sel = dbg_r;
    hold_d    = sel;
    mem_en    = cpu_gnt | dbg_gnt;
    mem_we    = mem_en & sel.we;
    mem_addr  = sel.addr;
    mem_wdata = sel.wdata;
    mem_be    = sel.be;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CPU_PRI:    if (dbg_gnt && dbg_lock) state_d = DBG_LOCKED;
      DBG_LOCKED: if (!dbg_lock)           state_d = CPU_PRI;
      default:    state_d = CPU_PRI;
    endcase

    wait_cnt_d = wait_cnt_q;
    if (!dbg_req || dbg_gnt)     wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT) wait_cnt_d = wait_cnt_q + 4'd1;

    rd_vld_d = mem_en & ~mem_we;
    rd_dbg_d = dbg_gnt;
  end

  // Return path: tag from last cycle selects which port sees mem_rdata.
  always_comb begin
    cpu_rvalid  = rd_vld_q & ~rd_dbg_q & ~rst;
    dbg_rvalid  = rd_vld_q &  rd_dbg_q & ~rst;
    cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    dbg_rdata   = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    cpu_rdata_d = cpu_rdata;
    dbg_rdata_d = dbg_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CPU_PRI;
      wait_cnt_q  <= '0;
      rd_vld_q    <= 1'b0;
      rd_dbg_q    <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      rd_vld_q    <= rd_vld_d;
      rd_dbg_q    <= rd_dbg_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous single-port memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [6:0]  cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        dbg_req, dbg_we, dbg_lock, dbg_gnt, dbg_rvalid;
  logic [6:0]  dbg_addr;
  logic [31:0] dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_be;
  logic        mem_en, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic [31:0] mem [128];
  int checks = 0;
  int errors = 0;
  int rv_cnt;

  always #5 clk = ~clk;

  dmem_arbiter #(.XLEN(32), .ADDR_W(7), .DBG_MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_be(dbg_be), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0; cpu_be = 4'hF;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_be = 4'hF; dbg_lock = 0;
  endtask

  initial begin
    for (int j = 0; j < 128; j++) mem[j] <= 32'hC0DE0000 | 32'(j);
    mem[5] <= 32'h0000000A;
    mem[2] <= 32'hAAAAAAAA;
    idle();
    rst = 1;
    cpu_req = 1; dbg_req = 1;

    // Reset: requests high but nothing granted
    tick(); #1;
    chk1("rst_cpu_gnt", cpu_gnt, 0);
    chk1("rst_dbg_gnt", dbg_gnt, 0);
    chk1("rst_stall", cpu_stall, 0);
    chk1("rst_mem_en", mem_en, 0);
    chk1("rst_mem_we", mem_we, 0);
    chk1("rst_cpu_rvalid", cpu_rvalid, 0);
    chk1("rst_dbg_rvalid", dbg_rvalid, 0);
    chk32("rst_cpu_rdata", cpu_rdata, 0);
    chk32("rst_dbg_rdata", dbg_rdata, 0);
    tick();
    rst = 0; idle();

    // Simple cpu load of addr 5
    tick();
    cpu_req = 1; cpu_addr = 7'd5; #1;
    chk1("t1_cpu_gnt", cpu_gnt, 1);
    chk1("t1_mem_en", mem_en, 1);
    chk1("t1_mem_we", mem_we, 0);
    chk32("t1_mem_addr", 32'(mem_addr), 32'd5);
    chk1("t1_stall", cpu_stall, 0);
    tick();
    cpu_req = 0; #1;
    chk1("t1_cpu_rvalid", cpu_rvalid, 1);
    chk32("t1_cpu_rdata", cpu_rdata, 32'h0000000A);
    chk1("t1_dbg_rvalid", dbg_rvalid, 0);

    // Starvation guard: both requesting, dbg forced every 5th cycle
    for (int i = 0; i < 10; i++) begin
      tick();
      cpu_req = 1; cpu_addr = 7'd5;
      dbg_req = 1; dbg_addr = 7'd6; #1;
      chk1("t2_cpu_gnt", cpu_gnt, (i % 5) != 4);
      chk1("t2_dbg_gnt", dbg_gnt, (i % 5) == 4);
      chk1("t2_stall", cpu_stall, (i % 5) == 4);
      if (i == 4) chk32("t2_mem_addr", 32'(mem_addr), 32'd6);
      if (i == 5) begin
        chk1("t2_dbg_rvalid", dbg_rvalid, 1);
        chk32("t2_dbg_rdata", dbg_rdata, 32'hC0DE0006);
      end
    end
    tick();
    idle(); #1;

    // Locked dbg burst: forced store then three locked reads
    for (int i = 0; i < 5; i++) begin
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 7'd5;
      dbg_req = 1; dbg_we = 1; dbg_addr = 7'd9; dbg_wdata = 32'hABC00000; dbg_lock = 1; #1;
      chk1("t3_cpu_gnt", cpu_gnt, i != 4);
      chk1("t3_dbg_gnt", dbg_gnt, i == 4);
      if (i == 4) begin
        chk1("t3_store_we", mem_we, 1);
        chk32("t3_store_addr", 32'(mem_addr), 32'd9);
      end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      dbg_we = 0; dbg_addr = 7'(9 + k); #1;
      chk1("t3_lk_dbg_gnt", dbg_gnt, 1);
      chk1("t3_lk_cpu_gnt", cpu_gnt, 0);
      chk1("t3_lk_stall", cpu_stall, 1);
      chk1("t3_lk_dbg_rvalid", dbg_rvalid, k != 0);
      if (k == 1) chk32("t3_rd9", dbg_rdata, 32'hABC00000);
      if (k == 2) chk32("t3_rd10", dbg_rdata, 32'hC0DE000A);
    end
    tick();
    dbg_req = 0; dbg_lock = 0; #1;
    chk1("t3_drop_cpu_gnt", cpu_gnt, 0);
    chk1("t3_drop_stall", cpu_stall, 1);
    chk1("t3_drop_mem_en", mem_en, 0);
    chk1("t3_drop_dbg_rvalid", dbg_rvalid, 1);
    chk32("t3_rd11", dbg_rdata, 32'hC0DE000B);
    tick(); #1;
    chk1("t3_back_cpu_gnt", cpu_gnt, 1);
    chk1("t3_back_stall", cpu_stall, 0);

    // cpu partial store beats simultaneous dbg read of same word
    tick();
    cpu_req = 1; cpu_we = 1; cpu_addr = 7'd2; cpu_wdata = 32'h12345678; cpu_be = 4'b0011;
    dbg_req = 1; dbg_we = 0; dbg_addr = 7'd2; #1;
    chk1("t4_cpu_gnt", cpu_gnt, 1);
    chk1("t4_dbg_gnt", dbg_gnt, 0);
    chk1("t4_mem_we", mem_we, 1);
    chk32("t4_mem_be", 32'(mem_be), 32'h3);
    chk32("t4_mem_wdata", mem_wdata, 32'h12345678);
    tick();
    cpu_req = 0; cpu_we = 0; cpu_be = 4'hF; #1;
    chk1("t4_dbg_gnt2", dbg_gnt, 1);
    chk1("t4_cpu_rvalid", cpu_rvalid, 0);
    tick();
    dbg_req = 0; #1;
    chk1("t4_dbg_rvalid", dbg_rvalid, 1);
    chk32("t4_dbg_rdata", dbg_rdata, 32'hAAAA5678);

    // Reset between a granted read and its return
    tick();
    cpu_req = 1; cpu_addr = 7'd5; #1;
    chk1("t5_cpu_gnt", cpu_gnt, 1);
    tick();
    cpu_req = 0; rst = 1; #1;
    chk1("t5_rst_rvalid", cpu_rvalid, 0);
    chk1("t5_rst_mem_en", mem_en, 0);
    tick();
    rst = 0; #1;
    chk1("t5_cpu_rvalid", cpu_rvalid, 0);
    chk32("t5_cpu_rdata", cpu_rdata, 0);
    chk32("t5_dbg_rdata", dbg_rdata, 0);
    chk1("t5_state", dut.state_q, 1'b0);
    chk32("t5_wait_cnt", 32'(dut.wait_cnt_q), 0);

    // Alternating cpu loads/stores, no dbg
    rv_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      cpu_req = 1; cpu_we = i[0]; cpu_addr = 7'(40 + i); cpu_wdata = 32'(i); cpu_be = 4'hF; #1;
      chk1("t6_stall", cpu_stall, 0);
      chk1("t6_cpu_gnt", cpu_gnt, 1);
      if (cpu_rvalid) rv_cnt++;
      if (i > 0) chk1("t6_rvalid", cpu_rvalid, i[0]);
      if (i[0]) chk32("t6_rdata", cpu_rdata, 32'hC0DE0000 | 32'(40 + i - 1));
    end
    tick();
    idle(); #1;
    if (cpu_rvalid) rv_cnt++;
    chk32("t6_rvalid_count", 32'(rv_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
